// File: rtl/magic_pkg.sv
// Shared types and default constants for the magic-mode NMI controller.
// Both the controller and its config register file import this package.
package magic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_NMI_PEND   = 3'd1,
    ST_CHECK_SIG  = 3'd2,
    ST_MAPPED     = 3'd3,
    ST_UNMAP_WAIT = 3'd4,
    ST_REMAP_WAIT = 3'd5
  } magic_state_t;

  localparam logic [15:0] NMI_VEC_DEF      = 16'h0066;
  localparam logic [15:0] EXIT_ADDR_DEF    = 16'hF000;
  localparam logic [15:0] REENTER_ADDR_DEF = 16'hF008;
  localparam logic [7:0]  CFG_PORT_DEF     = 8'hFF;
  localparam logic [7:0]  SIG_BYTE_DEF     = 8'hEB;

  localparam logic [7:0]  IDX_LIVE   = 8'h00;
  localparam logic [7:0]  IDX_STATUS = 8'hFF;

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) begin
        r = 3'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/magic_cfg_regs.sv
// Config register file behind the magic I/O port: write decode and a
// registered readback mux covering live sources, registers and status.
module magic_cfg_regs
  import magic_pkg::*;
#(
  parameter int                     NUM_CFG   = 13,
  parameter logic [8*NUM_CFG-1:0]   CFG_RESET = '0
) (
  input  logic                   i_clk28,
  input  logic                   i_rst,
  input  logic                   i_cs,
  input  logic                   i_wr,
  input  logic                   i_rd,
  input  logic [7:0]             i_idx,
  input  logic [7:0]             i_d,
  input  logic [7:0]             i_live,
  input  logic [7:0]             i_status,
  output logic [8*NUM_CFG-1:0]   o_cfg_q,
  output logic [7:0]             o_d_out,
  output logic                   o_d_out_active
);

  logic [8*NUM_CFG-1:0] r_cfg;
  logic [8*NUM_CFG-1:0] w_cfg_nxt;
  logic [7:0]           r_d_out;
  logic                 r_d_out_active;
  logic                 w_wr_en;
  logic                 w_reg_hit;
  logic [7:0]           w_reg_data;
  logic                 w_rd_hit;
  logic [7:0]           w_rd_data;

  assign w_wr_en = i_cs && i_wr;

  // Per-register write select; every wr cycle overwrites, so the last value wins.
  always_comb begin
    w_cfg_nxt  = r_cfg;
    w_reg_hit  = 1'b0;
    w_reg_data = 8'h00;
    for (int i = 1; i <= NUM_CFG; i++) begin
      w_cfg_nxt[8*i-1 -: 8] = (w_wr_en && (i_idx == 8'(i))) ? i_d : r_cfg[8*i-1 -: 8];
      w_reg_hit  = w_reg_hit | (i_idx == 8'(i));
      w_reg_data = w_reg_data | (r_cfg[8*i-1 -: 8] & {8{i_idx == 8'(i)}});
    end
  end

  // Readback source select for the addressed index.
  always_comb begin
    w_rd_hit  = 1'b0;
    w_rd_data = 8'h00;
    if (i_idx == IDX_LIVE) begin
      w_rd_hit  = 1'b1;
      w_rd_data = i_live;
    end else if (i_idx == IDX_STATUS) begin
      w_rd_hit  = 1'b1;
      w_rd_data = i_status;
    end else begin
      w_rd_hit  = w_reg_hit;
      w_rd_data = w_reg_data;
    end
  end

  // Register file storage.
  always_ff @(posedge i_clk28 or posedge i_rst) begin
    if (i_rst) begin
      r_cfg <= CFG_RESET;
    end else begin
      r_cfg <= w_cfg_nxt;
    end
  end

  // Registered readback; drive enable drops the cycle after rd falls.
  always_ff @(posedge i_clk28 or posedge i_rst) begin
    if (i_rst) begin
      r_d_out        <= 8'h00;
      r_d_out_active <= 1'b0;
    end else if (i_cs && i_rd) begin
      r_d_out_active <= w_rd_hit;
      r_d_out        <= w_rd_hit ? w_rd_data : r_d_out;
    end else begin
      r_d_out_active <= 1'b0;
    end
  end

  assign o_cfg_q        = r_cfg;
  assign o_d_out        = r_d_out;
  assign o_d_out_active = r_d_out_active;

endmodule

// File: rtl/magic_nmi_ctrl.sv
// Magic-mode controller: NMI source arbitration and acknowledge timeout,
// magic ROM map/unmap sequencing with signature check, and sticky status.
module magic_nmi_ctrl
  import magic_pkg::*;
#(
  parameter int                    NUM_SRC        = 2,
  parameter int                    NUM_CFG        = 13,
  parameter logic [8*NUM_CFG-1:0]  CFG_RESET      = '0,
  parameter logic [7:0]            SIG_BYTE       = SIG_BYTE_DEF,
  parameter logic [15:0]           NMI_VEC        = NMI_VEC_DEF,
  parameter logic [15:0]           EXIT_ADDR      = EXIT_ADDR_DEF,
  parameter logic [15:0]           REENTER_ADDR   = REENTER_ADDR_DEF,
  parameter logic [7:0]            CFG_PORT       = CFG_PORT_DEF,
  parameter bit                    MAGIC_ON_START = 1'b1,
  parameter int                    NMI_TIMEOUT    = 65535
) (
  input  logic                   i_clk28,
  input  logic                   i_rst,
  input  logic [15:0]            i_a,
  input  logic [7:0]             i_d,
  input  logic                   i_mreq,
  input  logic                   i_ioreq,
  input  logic                   i_rd,
  input  logic                   i_wr,
  input  logic                   i_m1,
  input  logic                   i_frame_tick,
  input  logic [NUM_SRC-1:0]     i_src,
  input  logic [NUM_SRC-1:0]     i_src_en,
  output logic                   o_n_nmi,
  output logic                   o_magic_mode,
  output logic                   o_magic_map,
  output logic [8*NUM_CFG-1:0]   o_cfg_q,
  output logic [7:0]             o_d_out,
  output logic                   o_d_out_active
);

  localparam int              TW         = $clog2(NMI_TIMEOUT + 1);
  localparam logic [TW-1:0]   TIMER_LAST = TW'(NMI_TIMEOUT - 1);
  localparam logic [TW-1:0]   TIMER_ONE  = TW'(1);
  localparam magic_state_t    RST_STATE  = MAGIC_ON_START ? ST_CHECK_SIG : ST_IDLE;

  magic_state_t  r_state, w_state_nxt;
  logic          r_n_nmi, w_n_nmi_nxt;
  logic          r_mode, w_mode_nxt;
  logic          r_map, w_map_nxt;
  logic [2:0]    r_cause, w_cause_nxt;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic          r_match, w_match_nxt;
  logic          r_reading, w_reading_nxt;
  logic          r_reenter, w_reenter_nxt;
  logic          r_sig_fail, w_sig_fail_nxt;
  logic          r_nmi_to, w_nmi_to_nxt;
  logic          r_status_rd;
  logic          w_set_sig_fail, w_set_nmi_to;

  logic [7:0]    w_src8, w_pend8, w_status, w_idx;
  logic          w_cfg_cs, w_status_rd, w_flag_clr, w_fetch;

  // Zero-extend source vectors to the byte-wide status/arbitration width.
  always_comb begin
    w_src8                 = 8'h00;
    w_pend8                = 8'h00;
    w_src8[NUM_SRC-1:0]    = i_src;
    w_pend8[NUM_SRC-1:0]   = i_src & i_src_en;
  end

  assign w_idx       = i_a[15:8];
  assign w_cfg_cs    = r_map && i_ioreq && (i_a[7:0] == CFG_PORT);
  assign w_status_rd = w_cfg_cs && i_rd && (w_idx == IDX_STATUS);
  assign w_flag_clr  = r_status_rd && !w_status_rd;
  assign w_fetch     = i_mreq && i_m1 && i_rd;
  assign w_status    = {r_sig_fail, r_nmi_to, 3'b000, r_cause};

  // Next-state and registered-output logic for the session FSM.
  always_comb begin
    w_state_nxt    = r_state;
    w_n_nmi_nxt    = r_n_nmi;
    w_mode_nxt     = r_mode;
    w_map_nxt      = r_map;
    w_cause_nxt    = r_cause;
    w_timer_nxt    = r_timer;
    w_match_nxt    = r_match;
    w_reading_nxt  = r_reading;
    w_reenter_nxt  = r_reenter;
    w_set_sig_fail = 1'b0;
    w_set_nmi_to   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_frame_tick && (w_pend8 != 8'h00)) begin
          w_cause_nxt = lowest_set(w_pend8);
          w_n_nmi_nxt = 1'b0;
          w_mode_nxt  = 1'b1;
          w_timer_nxt = '0;
          w_state_nxt = ST_NMI_PEND;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_NMI_PEND: begin
        // Acknowledge is tested first so it wins over a simultaneous timeout.
        if (i_m1 && i_mreq && (i_a == NMI_VEC)) begin
          w_n_nmi_nxt = 1'b1;
          w_map_nxt   = 1'b1;
          w_state_nxt = ST_CHECK_SIG;
        end else if (r_timer == TIMER_LAST) begin
          w_n_nmi_nxt  = 1'b1;
          w_mode_nxt   = 1'b0;
          w_set_nmi_to = 1'b1;
          w_state_nxt  = ST_IDLE;
        end else begin
          w_timer_nxt = r_timer + TIMER_ONE;
        end
      end
      ST_CHECK_SIG: begin
        if (!r_reading) begin
          if (w_fetch) begin
            w_match_nxt   = (i_d == SIG_BYTE);
            w_reading_nxt = 1'b1;
          end else begin
            w_reading_nxt = 1'b0;
          end
        end else if (!w_fetch) begin
          w_reading_nxt = 1'b0;
          if (r_match) begin
            w_state_nxt = ST_MAPPED;
          end else begin
            w_map_nxt      = 1'b0;
            w_mode_nxt     = 1'b0;
            w_set_sig_fail = 1'b1;
            w_state_nxt    = ST_IDLE;
          end
        end else begin
          w_reading_nxt = 1'b1;
        end
      end
      ST_MAPPED: begin
        if (i_mreq && i_rd && (i_a == EXIT_ADDR)) begin
          w_mode_nxt    = 1'b0;
          w_reenter_nxt = 1'b0;
          w_state_nxt   = ST_UNMAP_WAIT;
        end else if (i_mreq && i_rd && (i_a == REENTER_ADDR)) begin
          w_reenter_nxt = 1'b1;
          w_state_nxt   = ST_UNMAP_WAIT;
        end else begin
          w_state_nxt = ST_MAPPED;
        end
      end
      ST_UNMAP_WAIT: begin
        if (!i_mreq) begin
          w_map_nxt   = 1'b0;
          w_state_nxt = r_reenter ? ST_REMAP_WAIT : ST_IDLE;
        end else begin
          w_state_nxt = ST_UNMAP_WAIT;
        end
      end
      ST_REMAP_WAIT: begin
        if (i_m1 && i_mreq) begin
          w_map_nxt   = 1'b1;
          w_state_nxt = ST_MAPPED;
        end else begin
          w_state_nxt = ST_REMAP_WAIT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_n_nmi_nxt = 1'b1;
        w_mode_nxt  = 1'b0;
        w_map_nxt   = 1'b0;
      end
    endcase
  end

  // Sticky flags: a set in the clearing cycle takes priority.
  always_comb begin
    if (w_set_sig_fail) begin
      w_sig_fail_nxt = 1'b1;
    end else if (w_flag_clr) begin
      w_sig_fail_nxt = 1'b0;
    end else begin
      w_sig_fail_nxt = r_sig_fail;
    end
    if (w_set_nmi_to) begin
      w_nmi_to_nxt = 1'b1;
    end else if (w_flag_clr) begin
      w_nmi_to_nxt = 1'b0;
    end else begin
      w_nmi_to_nxt = r_nmi_to;
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk28 or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= RST_STATE;
      r_n_nmi     <= 1'b1;
      r_mode      <= MAGIC_ON_START;
      r_map       <= MAGIC_ON_START;
      r_cause     <= 3'd0;
      r_timer     <= '0;
      r_match     <= 1'b0;
      r_reading   <= 1'b0;
      r_reenter   <= 1'b0;
      r_sig_fail  <= 1'b0;
      r_nmi_to    <= 1'b0;
      r_status_rd <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_n_nmi     <= w_n_nmi_nxt;
      r_mode      <= w_mode_nxt;
      r_map       <= w_map_nxt;
      r_cause     <= w_cause_nxt;
      r_timer     <= w_timer_nxt;
      r_match     <= w_match_nxt;
      r_reading   <= w_reading_nxt;
      r_reenter   <= w_reenter_nxt;
      r_sig_fail  <= w_sig_fail_nxt;
      r_nmi_to    <= w_nmi_to_nxt;
      r_status_rd <= w_status_rd;
    end
  end

  magic_cfg_regs #(
    .NUM_CFG   (NUM_CFG),
    .CFG_RESET (CFG_RESET)
  ) u_cfg (
    .i_clk28        (i_clk28),
    .i_rst          (i_rst),
    .i_cs           (w_cfg_cs),
    .i_wr           (i_wr),
    .i_rd           (i_rd),
    .i_idx          (w_idx),
    .i_d            (i_d),
    .i_live         (w_src8),
    .i_status       (w_status),
    .o_cfg_q        (o_cfg_q),
    .o_d_out        (o_d_out),
    .o_d_out_active (o_d_out_active)
  );

  assign o_n_nmi      = r_n_nmi;
  assign o_magic_mode = r_mode;
  assign o_magic_map  = r_map;

endmodule

// File: tb/tb_magic_nmi_ctrl.sv
// Directed bench for magic_nmi_ctrl; readbacks are checked by a queue-based
// scoreboard monitor, control outputs by direct comparisons.
module tb_magic_nmi_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  addr;
  logic [7:0]   dat;
  logic         mreq, ioreq, rd, wr, m1, tick;
  logic [1:0]   src, src_en;
  logic         n_nmi, mode, map, dout_act;
  logic [103:0] cfg_q;
  logic [103:0] exp_cfg;
  logic [7:0]   dout;

  int           checks = 0;
  int           errors = 0;
  logic [7:0]   exp_q[$];
  int           cnt;

  always #5 clk = ~clk;

  magic_nmi_ctrl #(.NMI_TIMEOUT(16)) dut (
    .i_clk28(clk), .i_rst(rst), .i_a(addr), .i_d(dat),
    .i_mreq(mreq), .i_ioreq(ioreq), .i_rd(rd), .i_wr(wr), .i_m1(m1),
    .i_frame_tick(tick), .i_src(src), .i_src_en(src_en),
    .o_n_nmi(n_nmi), .o_magic_mode(mode), .o_magic_map(map),
    .o_cfg_q(cfg_q), .o_d_out(dout), .o_d_out_active(dout_act)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic bus(input logic [15:0] ta, input logic [7:0] td,
                     input logic tmreq, input logic tio, input logic trd,
                     input logic twr, input logic tm1);
    @(posedge clk);
    #1;
    addr = ta; dat = td; mreq = tmreq; ioreq = tio; rd = trd; wr = twr; m1 = tm1;
  endtask

  task automatic idle();                                   bus(16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); endtask
  task automatic fetch(input logic [15:0] ta, input logic [7:0] td); bus(ta, td, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1); endtask
  task automatic memrd(input logic [15:0] ta);              bus(ta, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); endtask
  task automatic io_wr(input logic [15:0] ta, input logic [7:0] td); bus(ta, td, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0); endtask
  task automatic io_rd(input logic [15:0] ta);              bus(ta, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0); endtask

  task automatic rd_exp(input logic [15:0] ta, input logic [7:0] e);
    exp_q.push_back(e);
    io_rd(ta);
    idle();
  endtask

  task automatic trigger(input logic [1:0] s, input logic [1:0] en);
    src = s; src_en = en; tick = 1'b1;
    idle();
    tick = 1'b0;
  endtask

  // Scoreboard monitor: every active readback cycle consumes one expected byte.
  always @(negedge clk) begin
    if (!rst && dout_act) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL readback: unexpected data %02h, expected none", dout);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (dout !== e) begin
          errors++;
          $display("FAIL readback: got %02h, expected %02h", dout, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; addr = 16'h0; dat = 8'h0; mreq = 1'b0; ioreq = 1'b0; rd = 1'b0;
    wr = 1'b0; m1 = 1'b0; tick = 1'b0; src = 2'b00; src_en = 2'b00;
    exp_cfg = '0;
    repeat (3) idle();
    rst = 1'b0;
    idle();
    chk("reset n_nmi", n_nmi, 1'b1);
    chk("reset mode", mode, 1'b1);
    chk("reset map", map, 1'b1);
    chk("reset cfg_q", cfg_q, exp_cfg);
    chk("reset d_out_active", dout_act, 1'b0);

    // Bad signature straight out of reset.
    fetch(16'h0000, 8'h00);
    idle();
    chk("sig fetch map held", map, 1'b1);
    idle();
    chk("sig fail map", map, 1'b0);
    chk("sig fail mode", mode, 1'b0);

    // NMI from source 0, acknowledge, good signature.
    trigger(2'b01, 2'b01);
    chk("trig0 n_nmi", n_nmi, 1'b0);
    chk("trig0 mode", mode, 1'b1);
    fetch(16'h0066, 8'hEB);
    fetch(16'h0066, 8'hEB);
    idle();
    chk("ack0 n_nmi", n_nmi, 1'b1);
    chk("ack0 map", map, 1'b1);
    idle();
    rd_exp(16'hFFFF, 8'h80);
    rd_exp(16'hFFFF, 8'h00);

    // Config writes and reads while mapped.
    io_wr(16'h05FF, 8'hA5);
    io_wr(16'h0DFF, 8'h5A);
    io_wr(16'h0EFF, 8'h77);
    idle();
    exp_cfg[39:32]   = 8'hA5;
    exp_cfg[103:96]  = 8'h5A;
    chk("cfg writes", cfg_q, exp_cfg);
    rd_exp(16'h05FF, 8'hA5);
    rd_exp(16'h0DFF, 8'h5A);
    rd_exp(16'h00FF, 8'h01);
    io_rd(16'h20FF);
    idle();
    chk("bad index inactive", dout_act, 1'b0);

    // Reenter: unmap for one instruction.
    memrd(16'hF008);
    memrd(16'hF009);
    chk("reenter map held", map, 1'b1);
    idle();
    idle();
    chk("reenter unmapped", map, 1'b0);
    chk("reenter mode kept", mode, 1'b1);
    src = 2'b11; src_en = 2'b11; tick = 1'b1;
    idle();
    tick = 1'b0;
    idle();
    chk("tick ignored", n_nmi, 1'b1);
    io_wr(16'h05FF, 8'h3C);
    idle();
    chk("unmapped write ignored", cfg_q, exp_cfg);
    io_rd(16'h05FF);
    idle();
    chk("unmapped read silent", dout_act, 1'b0);
    fetch(16'h0100, 8'h00);
    idle();
    chk("remap map", map, 1'b1);
    idle();
    chk("remap no sig check map", map, 1'b1);
    chk("remap no sig check mode", mode, 1'b1);

    // Exit to IDLE.
    memrd(16'hF000);
    idle();
    chk("exit mode", mode, 1'b0);
    chk("exit map held", map, 1'b1);
    idle();
    chk("exit map", map, 1'b0);

    // Acknowledge timeout, cause 1.
    trigger(2'b10, 2'b10);
    cnt = 0;
    while (n_nmi === 1'b0 && cnt < 40) begin
      idle();
      cnt++;
    end
    chk("timeout cycles", cnt, 16);
    chk("timeout mode", mode, 1'b0);

    // Lowest enabled source wins; enter session and read status.
    trigger(2'b11, 2'b10);
    chk("trig1 n_nmi", n_nmi, 1'b0);
    fetch(16'h0066, 8'hEB);
    fetch(16'h0066, 8'hEB);
    idle();
    chk("ack1 n_nmi", n_nmi, 1'b1);
    chk("ack1 map", map, 1'b1);
    idle();
    rd_exp(16'hFFFF, 8'h41);
    rd_exp(16'hFFFF, 8'h01);

    // Reset in the middle of a pending NMI.
    memrd(16'hF000);
    idle();
    idle();
    trigger(2'b01, 2'b01);
    chk("pre-reset n_nmi", n_nmi, 1'b0);
    rst = 1'b1;
    #1;
    chk("async reset n_nmi", n_nmi, 1'b1);
    chk("async reset map", map, 1'b1);
    chk("async reset cfg_q", cfg_q, 104'h0);
    idle();
    rst = 1'b0;
    idle();
    rd_exp(16'hFFFF, 8'h00);

    repeat (3) idle();
    chk("readback queue drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
